// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbitration slice: operation encodings,
// flag bundle and datapath width.
package alu_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    ALU_PASS_B   = 3'b000,
    ALU_ADD      = 3'b010,
    ALU_SUBTRACT = 3'b011,
    ALU_AND      = 3'b100,
    ALU_OR       = 3'b101,
    ALU_XOR      = 3'b110
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu.sv
// Combinational 64-bit ALU. Carry on subtract is "no borrow"; logical ops and
// unknown encodings report C=V=0, and unknown encodings produce a zero result.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        cntrl,
  output logic [DATA_W-1:0] result,
  output logic              negative,
  output logic              zero,
  output logic              overflow,
  output logic              carry_out
);

  alu_op_t            op;
  logic               sub;
  logic [DATA_W-1:0]  b_eff;
  logic [DATA_W:0]    sum;

  assign op = alu_op_t'(cntrl);

  always_comb begin
    sub       = (op == ALU_SUBTRACT);
    b_eff     = sub ? ~b : b;
    sum       = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
    result    = '0;
    carry_out = 1'b0;
    overflow  = 1'b0;
    case (op)
      ALU_PASS_B: result = b;
      ALU_ADD, ALU_SUBTRACT: begin
        result    = sum[DATA_W-1:0];
        carry_out = sum[DATA_W];
        overflow  = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
    negative = result[DATA_W-1];
    zero     = (result == '0);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from last_grant+1 and only moves its pointer
// when the caller reports that the grant was actually taken.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  input  logic         accept,
  output logic [N-1:0] grant
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    win   = last_q;
    idx   = last_q;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = IDW'((int'(last_q) + i) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    grant = '0;
    if (enable && found) grant[win] = 1'b1;
    last_d = accept ? win : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= IDW'(N - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin grant into an operand
// register, ALU evaluation, one-entry response buffer, plus the NZCV register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]      req_cntrl,
  input  logic [NUM_REQ-1:0]        req_setflags,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_negative,
  output logic                      rsp_zero,
  output logic                      rsp_overflow,
  output logic                      rsp_carry_out,
  output logic                      flag_n,
  output logic                      flag_z,
  output logic                      flag_c,
  output logic                      flag_v
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  logic [2:0]        c_arr [NUM_REQ];

  logic              op_valid_q, op_valid_d;
  logic [IDW-1:0]    op_id_q, op_id_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]        op_cntrl_q, op_cntrl_d;
  logic              op_setflags_q, op_setflags_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  alu_flags_t        rsp_flags_q, rsp_flags_d;
  alu_flags_t        flags_q, flags_d;

  logic [DATA_W-1:0] alu_result;
  alu_flags_t        alu_flags;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]    grant_id;
  logic              accept, rsp_hs, op_adv, grant_possible;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign a_arr[gi]     = req_a[gi*DATA_W +: DATA_W];
      assign b_arr[gi]     = req_b[gi*DATA_W +: DATA_W];
      assign c_arr[gi]     = req_cntrl[gi*3 +: 3];
      assign rsp_valid[gi] = rsp_valid_q && (rsp_id_q == IDW'(gi));
    end
  endgenerate

  assign rsp_hs         = rsp_valid_q && rsp_ready[rsp_id_q];
  assign op_adv         = op_valid_q && (!rsp_valid_q || rsp_hs);
  assign grant_possible = !op_valid_q || op_adv;
  assign req_ready      = grant;
  assign accept         = |(req_valid & grant);

  // rst_n gates the enable so req_ready reads 0 for the whole reset window
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .enable (grant_possible && rst_n),
    .accept (accept),
    .grant  (grant)
  );

  alu u_alu (
    .a         (op_a_q),
    .b         (op_b_q),
    .cntrl     (op_cntrl_q),
    .result    (alu_result),
    .negative  (alu_flags.n),
    .zero      (alu_flags.z),
    .overflow  (alu_flags.v),
    .carry_out (alu_flags.c)
  );

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
  end

  always_comb begin
    op_valid_d    = op_valid_q;
    op_id_d       = op_id_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_cntrl_d    = op_cntrl_q;
    op_setflags_d = op_setflags_q;
    if (accept) begin
      op_valid_d    = 1'b1;
      op_id_d       = grant_id;
      op_a_d        = a_arr[grant_id];
      op_b_d        = b_arr[grant_id];
      op_cntrl_d    = c_arr[grant_id];
      op_setflags_d = req_setflags[grant_id];
    end else if (op_adv) begin
      op_valid_d = 1'b0;
    end

    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    if (op_adv) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = op_id_q;
      rsp_result_d = alu_result;
      rsp_flags_d  = alu_flags;
    end else if (rsp_hs) begin
      rsp_valid_d = 1'b0;
    end

    // NZCV commits with the op entering RSP, so flags track issue order
    flags_d = flags_q;
    if (op_adv && op_setflags_q) begin
      case (alu_op_t'(op_cntrl_q))
        ALU_ADD, ALU_SUBTRACT: flags_d = alu_flags;
        ALU_PASS_B, ALU_AND, ALU_OR, ALU_XOR: begin
          flags_d.n = alu_flags.n;
          flags_d.z = alu_flags.z;
          flags_d.c = 1'b0;
          flags_d.v = 1'b0;
        end
        default: flags_d = flags_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q    <= 1'b0;
      op_id_q       <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_cntrl_q    <= '0;
      op_setflags_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      flags_q       <= '0;
    end else begin
      op_valid_q    <= op_valid_d;
      op_id_q       <= op_id_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_cntrl_q    <= op_cntrl_d;
      op_setflags_q <= op_setflags_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      flags_q       <= flags_d;
    end
  end

  assign rsp_result    = rsp_result_q;
  assign rsp_negative  = rsp_flags_q.n;
  assign rsp_zero      = rsp_flags_q.z;
  assign rsp_overflow  = rsp_flags_q.v;
  assign rsp_carry_out = rsp_flags_q.c;
  assign flag_n        = flags_q.n;
  assign flag_z        = flags_q.z;
  assign flag_c        = flags_q.c;
  assign flag_v        = flags_q.v;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 64-bit combinational `alu` between `NUM_REQ` requesters, such as the execute stage and an address-generation unit, using round-robin arbitration with valid/ready handshakes. Each accepted request is registered, evaluated by the `alu`, and returned through a one-entry response buffer. The block also keeps the architectural NZCV flag register, which set-flags requests update. It sits between the issue logic and the `alu` instance in the datapath.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit high.
- `req_a`, `req_b` in `NUM_REQ`×64: operands.
- `req_cntrl` in `NUM_REQ`×3: ALU op (000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR).
- `req_setflags` in `NUM_REQ`: request updates NZCV.
- `rsp_valid` out `NUM_REQ`: one-hot response valid, addressed to the originating requester.
- `rsp_ready` in `NUM_REQ`: per-requester response accept.
- `rsp_result` out 64: registered ALU result.
- `rsp_negative`, `rsp_zero`, `rsp_overflow`, `rsp_carry_out` out 1 each: registered ALU flags for this op.
- `flag_n`, `flag_z`, `flag_c`, `flag_v` out 1 each: architectural flag register.

## Operation
- **Two-stage pipeline.**
  - Operand stage (OP): valid bit, requester id, a, b, cntrl, setflags.
  - Response stage (RSP): valid bit, id, result, four flags.
  - `alu` is driven from the OP registers.
- **Advance rules.**
  - OP→RSP when OP valid and (RSP empty or RSP handshaking this cycle).
  - Grant is possible when OP is empty or OP is advancing this cycle.
- **Round-robin arbitration.**
  - Priority starts at `last_grant+1` mod `NUM_REQ`.
  - The winner is the first requester with `req_valid` high.
  - `req_ready[winner]` is high only if a grant is possible; all other bits are 0.
  - `req_ready` may depend combinationally on `req_valid`.
  - `last_grant` updates only on an accepted handshake.
- **Response handshake.**
  - The handshake is `rsp_valid[id] && rsp_ready[id]`.
  - RSP contents hold stable until accepted.
  - `rsp_ready` of non-addressed requesters is ignored.
- **Flag update.** Occurs on the edge where an op moves OP→RSP with setflags=1.
  - ADD/SUB: N, Z, C, V all take the ALU flags.
  - PASS_B/AND/OR/XOR: N, Z take the ALU flags; C and V are cleared.
  - Undefined cntrl (001, 111): flags are not updated. The response is still returned with the ALU's outputs.
- **Reset (assertion at any time, including mid-operation).**
  - OP and RSP are invalidated and in-flight ops are dropped without a response.
  - `last_grant` is set to `NUM_REQ-1`, so requester 0 has priority first.
  - NZCV is cleared.
  - All outputs read 0: `req_ready`, `rsp_valid`, `rsp_result`, rsp flags, `flag_*`.

## Timing
- **Latency:** a request accepted at edge E0 loads OP at E0 and RSP at E1, so `rsp_valid` is high from after E1, a 2-edge latency when RSP is free.
- **Throughput:** one op per cycle with `rsp_ready` held high.
- **Full pipeline:** with RSP full and not accepted, and OP valid, `req_ready` is all 0. The pipeline holds two ops maximum.
- **Simultaneous RSP accept and OP advance:** on the same edge, RSP takes the new op and a new request may enter OP. There is no bubble.
- **Flag visibility:** `flag_*` change at E1, together with `rsp_valid`. A setflags op followed back-to-back by another sees updates in order, since the issue order is the pipeline order.
- There are no combinational paths from `rsp_ready` to `rsp_*` outputs.

## Structure
- **`alu_pkg`:**
  - `alu_op_t` enum with ALU_PASS_B=000, ALU_ADD=010, ALU_SUBTRACT=011, ALU_AND=100, ALU_OR=101, ALU_XOR=110.
  - `alu_flags_t` struct (n, z, c, v).
  - `DATA_W=64` constant.
- **`rr_arbiter` sub-module** (parametrised by N): inputs `req`, `enable`, `accept`; output one-hot `grant`. It holds the `last_grant` register.
- `alu_arbiter` instantiates `rr_arbiter`, one `alu`, and the OP/RSP registers plus the NZCV register.

## Test plan
- **Single ADD.** Requester 0 sends a=1, b=1, ADD, setflags=1 with `rsp_ready` high.
  - `rsp_valid[0]` is high 2 edges later with result=2.
  - NZCV=0000.
- **Contention.** Both requesters hold valid every cycle, each sending SUB with a=b=0x111.
  - Grants alternate 0,1,0,1.
  - Each result is 0 with zero=1 and carry_out=1.
  - Responses are tagged to the correct requester.
- **Backpressure.** Hold `rsp_ready[0]`=0 after one ADD of 0xFFFF_FFFF_FFFF_FFFF+1.
  - A second request is accepted (OP full); the third sees `req_ready`=0.
  - The result stays 0 and C=1 is held until `rsp_ready` rises.
  - Then both responses drain in order.
- **Flag semantics.**
  - ADD 0x8000…0 + 0x8000…0 with setflags gives NZCV=0111.
  - A following AND with setflags of operands giving a nonzero positive result gives NZCV=0000.
  - Undefined cntrl 111 with setflags leaves NZCV unchanged.
- **Reset mid-flight.** Pull `rst_n` low while OP and RSP are both valid.
  - All outputs go to 0 immediately; no stale response appears after release.
  - The first grant after release goes to requester 0 when both request.
